// File: rtl/vend_sequencer.sv
// Coin vending controller: edge-captured coins, prioritised credit accumulation,
// timed product lamp and tick-paced change payout.
module vend_sequencer #(
  parameter int unsigned PRICE_A   = 12,
  parameter int unsigned PRICE_B   = 9,
  parameter int unsigned DISP_SECS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1s,
  input  logic       coin_u,
  input  logic       coin_d,
  input  logic       coin_c,
  input  logic       sel_p,
  input  logic       cancel,
  output logic [3:0] credit_bcd0,
  output logic [3:0] credit_bcd1,
  output logic [4:0] change_amt,
  output logic       lamp_a,
  output logic       lamp_b,
  output logic       pay_u,
  output logic       pay_d,
  output logic       coin_reject,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, DISPENSE, CHANGE, DONE} state_t;

  state_t     state_q, state_d;
  logic [4:0] credit_q, credit_d;
  logic [4:0] change_q, change_d;
  logic       prod_q, prod_d;
  logic [2:0] tick_cnt_q, tick_cnt_d;
  logic [2:0] samp_q, samp_d;
  logic [2:0] pend_q, pend_d;
  logic       pay_u_q, pay_u_d;
  logic       pay_d_q, pay_d_d;
  logic       reject_q, reject_d;

  logic [2:0] edges;
  logic [2:0] accept;
  logic [4:0] coin_val;
  logic [4:0] price;
  logic [4:0] sum;

  always_comb begin
    samp_d      = {coin_c, coin_d, coin_u};
    edges       = samp_d & ~samp_q;
    price       = sel_p ? 5'(PRICE_A) : 5'(PRICE_B);
    state_d     = state_q;
    credit_d    = credit_q;
    change_d    = change_q;
    prod_d      = prod_q;
    tick_cnt_d  = tick_cnt_q;
    pay_u_d     = 1'b0;
    pay_d_d     = 1'b0;
    reject_d    = 1'b0;
    accept      = '0;
    coin_val    = '0;
    sum         = '0;

    unique case (state_q)
      IDLE: begin
        if (credit_q >= price) begin
          change_d   = credit_q - price;
          prod_d     = sel_p;
          tick_cnt_d = '0;
          state_d    = DISPENSE;
        end else if (cancel && (credit_q != '0)) begin
          change_d = credit_q;
          state_d  = CHANGE;
        end else begin
          // Coins are only banked on cycles where credit stays live in IDLE.
          if (pend_q[2]) begin
            accept   = 3'b100;
            coin_val = 5'd5;
          end else if (pend_q[1]) begin
            accept   = 3'b010;
            coin_val = 5'd2;
          end else if (pend_q[0]) begin
            accept   = 3'b001;
            coin_val = 5'd1;
          end
          sum = credit_q + coin_val;
          if (accept != '0) begin
            if (sum > 5'd19) reject_d = 1'b1;
            else             credit_d = sum;
          end
        end
      end
      DISPENSE: begin
        if (tick_1s) begin
          if (tick_cnt_q == 3'(DISP_SECS - 1)) begin
            tick_cnt_d = '0;
            state_d    = CHANGE;
          end else begin
            tick_cnt_d = tick_cnt_q + 3'd1;
          end
        end
      end
      CHANGE: begin
        if (change_q == '0) begin
          state_d = DONE;
        end else if (tick_1s) begin
          if (change_q >= 5'd2) begin
            pay_d_d  = 1'b1;
            change_d = change_q - 5'd2;
          end else begin
            pay_u_d  = 1'b1;
            change_d = change_q - 5'd1;
          end
        end
      end
      DONE: begin
        credit_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A second edge on a slot whose coin has not yet been banked is lost.
    pend_d = (pend_q & ~accept) | edges;
    if ((edges & pend_q & ~accept) != '0) reject_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      credit_q   <= '0;
      change_q   <= '0;
      prod_q     <= 1'b0;
      tick_cnt_q <= '0;
      samp_q     <= '0;
      pend_q     <= '0;
      pay_u_q    <= 1'b0;
      pay_d_q    <= 1'b0;
      reject_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      change_q   <= change_d;
      prod_q     <= prod_d;
      tick_cnt_q <= tick_cnt_d;
      samp_q     <= samp_d;
      pend_q     <= pend_d;
      pay_u_q    <= pay_u_d;
      pay_d_q    <= pay_d_d;
      reject_q   <= reject_d;
    end
  end

  always_comb begin
    if (credit_q >= 5'd10) begin
      credit_bcd1 = 4'd1;
      credit_bcd0 = 4'(credit_q - 5'd10);
    end else begin
      credit_bcd1 = 4'd0;
      credit_bcd0 = credit_q[3:0];
    end
    change_amt  = change_q;
    lamp_a      = (state_q == DISPENSE) &&  prod_q;
    lamp_b      = (state_q == DISPENSE) && !prod_q;
    pay_u       = pay_u_q;
    pay_d       = pay_d_q;
    coin_reject = reject_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: purchases, change payout, arbitration,
// cancel, late select change, coin loss outside IDLE and reset during payout.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset, tick_1s, coin_u, coin_d, coin_c, sel_p, cancel;
  logic [3:0] credit_bcd0, credit_bcd1;
  logic [4:0] change_amt;
  logic       lamp_a, lamp_b, pay_u, pay_d, coin_reject, busy;

  int checks = 0;
  int failures = 0;
  int n_pay_u = 0, n_pay_d = 0, n_rej = 0, n_inv = 0;
  int s_pu, s_pd, s_rej;

  vend_sequencer #(.PRICE_A(12), .PRICE_B(9), .DISP_SECS(2)) dut (
    .clk(clk), .reset(reset), .tick_1s(tick_1s),
    .coin_u(coin_u), .coin_d(coin_d), .coin_c(coin_c),
    .sel_p(sel_p), .cancel(cancel),
    .credit_bcd0(credit_bcd0), .credit_bcd1(credit_bcd1),
    .change_amt(change_amt), .lamp_a(lamp_a), .lamp_b(lamp_b),
    .pay_u(pay_u), .pay_d(pay_d), .coin_reject(coin_reject), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pay_u === 1'b1) n_pay_u++;
    if (pay_d === 1'b1) n_pay_d++;
    if (coin_reject === 1'b1) n_rej++;
    if ((lamp_a & lamp_b) === 1'b1 || (pay_u & pay_d) === 1'b1) n_inv++;
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic tick();
    tick_1s = 1'b1; step(); tick_1s = 1'b0;
  endtask

  task automatic insert(input int v);
    if (v == 5) coin_c = 1'b1; else if (v == 2) coin_d = 1'b1; else coin_u = 1'b1;
    step();
    coin_c = 1'b0; coin_d = 1'b0; coin_u = 1'b0;
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 40 && busy; i++) begin
      tick(); step();
    end
    check(tag, busy, 0);
  endtask

  task automatic snap();
    s_pu = n_pay_u; s_pd = n_pay_d; s_rej = n_rej;
  endtask

  initial begin
    reset = 1'b1; tick_1s = 0; coin_u = 0; coin_d = 0; coin_c = 0; sel_p = 0; cancel = 0;
    step(); step();
    reset = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_bcd0", credit_bcd0, 0);
    check("rst_bcd1", credit_bcd1, 0);
    check("rst_change", change_amt, 0);
    check("rst_lamps", {lamp_a, lamp_b, pay_u, pay_d, coin_reject}, 0);

    // Product B, exact credit 9
    sel_p = 1'b0;
    insert(5);
    check("b_credit5", credit_bcd0, 5);
    insert(2);
    check("b_credit7", credit_bcd0, 7);
    coin_d = 1'b1; step(); coin_d = 1'b0; step();
    check("b_credit9", credit_bcd0, 9);
    check("b_not_yet_busy", busy, 0);
    step();
    check("b_lamp_b", lamp_b, 1);
    check("b_lamp_a", lamp_a, 0);
    check("b_change0", change_amt, 0);
    check("b_hold_disp", credit_bcd0, 9);
    snap();
    tick();
    check("b_lamp_tick1", lamp_b, 1);
    tick();
    check("b_lamp_off", lamp_b, 0);
    check("b_busy_change", busy, 1);
    step(); step();
    check("b_idle", busy, 0);
    check("b_credit_clr", {credit_bcd1, credit_bcd0}, 0);
    check("b_no_pay", (n_pay_u - s_pu) + (n_pay_d - s_pd), 0);

    // Product A with 15 -> change 3
    sel_p = 1'b1;
    insert(5); insert(5);
    check("a_credit10", {credit_bcd1, credit_bcd0}, 8'h10);
    coin_c = 1'b1; step(); coin_c = 1'b0; step();
    check("a_credit15", {credit_bcd1, credit_bcd0}, 8'h15);
    step();
    check("a_lamp_a", lamp_a, 1);
    check("a_change3", change_amt, 3);
    tick(); tick();
    check("a_lamp_off", lamp_a, 0);
    snap();
    tick();
    check("a_pay_d", pay_d, 1);
    check("a_pay_u_low", pay_u, 0);
    check("a_change1", change_amt, 1);
    step();
    check("a_pay_d_pulse", pay_d, 0);
    tick();
    check("a_pay_u", pay_u, 1);
    check("a_change0", change_amt, 0);
    step(); step();
    check("a_idle", busy, 0);
    check("a_credit_clr", {credit_bcd1, credit_bcd0}, 0);
    check("a_pay_counts", {n_pay_d - s_pd, n_pay_u - s_pu}, {32'd1, 32'd1});

    // Simultaneous 5 and 2 edges
    snap();
    coin_c = 1'b1; coin_d = 1'b1; step(); coin_c = 1'b0; coin_d = 1'b0;
    step();
    check("arb_first5", credit_bcd0, 5);
    step();
    check("arb_then7", credit_bcd0, 7);
    check("arb_no_reject", n_rej - s_rej, 0);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("arb_cancel_change", change_amt, 7);
    drain("arb_drain");
    check("arb_pays", {n_pay_d - s_pd, n_pay_u - s_pu}, {32'd3, 32'd1});
    check("arb_credit_clr", credit_bcd0, 0);

    // 2+2+2 then cancel
    insert(2); insert(2); insert(2);
    check("cx_credit6", credit_bcd0, 6);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("cx_change6", change_amt, 6);
    check("cx_hold", credit_bcd0, 6);
    snap();
    tick();
    check("cx_pay_d", pay_d, 1);
    check("cx_change4", change_amt, 4);
    step();
    drain("cx_drain");
    check("cx_pays", {n_pay_d - s_pd, n_pay_u - s_pu}, {32'd3, 32'd0});
    check("cx_credit_clr", credit_bcd0, 0);

    // Select flips to B with credit 9; coin lost while pending outside IDLE
    insert(5); insert(2); insert(2);
    step();
    check("sel_stay_idle", busy, 0);
    sel_p = 1'b0; step();
    check("sel_lamp_b", lamp_b, 1);
    check("sel_change0", change_amt, 0);
    sel_p = 1'b1; step();
    check("sel_ignored", {lamp_a, lamp_b}, 1);
    snap();
    insert(1);
    insert(1);
    check("dup_reject", n_rej - s_rej, 1);
    check("dup_credit_hold", credit_bcd0, 9);
    drain("sel_drain");
    step();
    check("pend_accepted", credit_bcd0, 1);
    snap();
    cancel = 1'b1; step(); cancel = 1'b0;
    drain("pend_drain");
    check("pend_refund", {n_pay_d - s_pd, n_pay_u - s_pu}, {32'd0, 32'd1});

    // Reset during CHANGE with change 3
    insert(5); insert(5); insert(5); step();
    tick(); tick();
    check("rc_change3", change_amt, 3);
    check("rc_busy", busy, 1);
    snap();
    reset = 1'b1; step(); reset = 1'b0;
    check("rc_idle", busy, 0);
    check("rc_outs", {credit_bcd1, credit_bcd0, 3'b000, change_amt, lamp_a, lamp_b, pay_u, pay_d, coin_reject}, 0);
    tick(); step(); tick(); step();
    check("rc_no_pay", (n_pay_u - s_pu) + (n_pay_d - s_pd), 0);
    cancel = 1'b1; step(); cancel = 1'b0;
    check("cancel_zero_ignored", busy, 0);

    check("invariants", n_inv, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
